// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB full-speed transmit line encoder.
// Sends SYNC, then the NRZI-encoded and bit-stuffed payload, then EOP (SE0 x N, J).
// All line and state updates happen on bit_strobe cycles only; tx_done clears on the next clk.
// Optional feature: define USB_TX_OE_EN to add the registered pad output-enable d_oe.
module usb_tx_encoder #(
  parameter logic [7:0]  SYNC_PATTERN = 8'h80,
  parameter int unsigned STUFF_LEN    = 6,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun,
  output logic       d_plus_out,
  output logic       d_minus_out
`ifdef USB_TX_OE_EN
  ,
  output logic       d_oe
`endif
);

  localparam int unsigned CNT_W = $clog2(STUFF_LEN + 1);
  localparam int unsigned SE0_W = $clog2(EOP_SE0_BITS + 1);
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [CNT_W-1:0]   r_ones_cnt;
  logic [SE0_W-1:0]   r_se0_cnt;
  logic [7:0]         r_shift;
  logic               r_last;
  logic               r_need_byte;
  logic               r_dp;
  logic               r_dm;
  logic               r_busy;
  logic               r_done;
  logic               r_underrun;

  state_t             w_nxt_state;
  logic [IDX_W-1:0]   w_nxt_bit_idx;
  logic [CNT_W-1:0]   w_nxt_ones_cnt;
  logic [SE0_W-1:0]   w_nxt_se0_cnt;
  logic [7:0]         w_nxt_shift;
  logic               w_nxt_last;
  logic               w_nxt_need_byte;
  logic               w_nxt_dp;
  logic               w_nxt_dm;
  logic               w_nxt_busy;
  logic               w_nxt_done;
  logic               w_nxt_underrun;
  logic               w_tx_ready;
  logic               w_stuff_due;
  logic               w_drive_bit;
  logic               w_tx_bit;

  assign w_stuff_due = (r_ones_cnt == CNT_W'(STUFF_LEN));

  // State and line registers; only bit_strobe cycles advance, tx_done self-clears.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_bit_idx   <= '0;
      r_ones_cnt  <= '0;
      r_se0_cnt   <= '0;
      r_shift     <= '0;
      r_last      <= 1'b0;
      r_need_byte <= 1'b0;
      r_dp        <= 1'b1;
      r_dm        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bit_strobe) begin
        r_state     <= w_nxt_state;
        r_bit_idx   <= w_nxt_bit_idx;
        r_ones_cnt  <= w_nxt_ones_cnt;
        r_se0_cnt   <= w_nxt_se0_cnt;
        r_shift     <= w_nxt_shift;
        r_last      <= w_nxt_last;
        r_need_byte <= w_nxt_need_byte;
        r_dp        <= w_nxt_dp;
        r_dm        <= w_nxt_dm;
        r_busy      <= w_nxt_busy;
        r_done      <= w_nxt_done;
        r_underrun  <= w_nxt_underrun;
      end
    end
  end

  // Next-state, byte fetch, bit stuffing and NRZI line encoding.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_bit_idx   = r_bit_idx;
    w_nxt_ones_cnt  = r_ones_cnt;
    w_nxt_se0_cnt   = r_se0_cnt;
    w_nxt_shift     = r_shift;
    w_nxt_last      = r_last;
    w_nxt_need_byte = r_need_byte;
    w_nxt_dp        = r_dp;
    w_nxt_dm        = r_dm;
    w_nxt_busy      = r_busy;
    w_nxt_done      = 1'b0;
    w_nxt_underrun  = r_underrun;
    w_tx_ready      = 1'b0;
    w_drive_bit     = 1'b0;
    w_tx_bit        = 1'b0;

    case (r_state)
      IDLE: begin
        w_nxt_dp = 1'b1;
        w_nxt_dm = 1'b0;
        if (tx_valid) begin
          w_nxt_state     = SYNC;
          w_nxt_busy      = 1'b1;
          w_nxt_underrun  = 1'b0;
          w_nxt_last      = 1'b0;
          w_nxt_need_byte = 1'b0;
          w_nxt_bit_idx   = IDX_W'(1);
          w_tx_bit        = SYNC_PATTERN[0];
          w_drive_bit     = 1'b1;
        end
      end

      SYNC: begin
        w_tx_bit    = SYNC_PATTERN[r_bit_idx];
        w_drive_bit = 1'b1;
        if (r_bit_idx == IDX_W'(7)) begin
          w_nxt_state     = DATA;
          w_nxt_need_byte = 1'b1;
          w_nxt_bit_idx   = '0;
        end else begin
          w_nxt_bit_idx = r_bit_idx + IDX_W'(1);
        end
      end

      DATA: begin
        if (w_stuff_due) begin
          // Stuffed 0: toggle the line without advancing the bit pointer.
          w_nxt_dp       = ~r_dp;
          w_nxt_dm       = ~r_dm;
          w_nxt_ones_cnt = '0;
        end else if (r_need_byte && r_last) begin
          w_nxt_state     = EOP_SE0;
          w_nxt_need_byte = 1'b0;
          w_nxt_se0_cnt   = SE0_W'(1);
          w_nxt_dp        = 1'b0;
          w_nxt_dm        = 1'b0;
        end else if (r_need_byte) begin
          w_tx_ready = bit_strobe;
          if (tx_valid) begin
            w_nxt_shift     = tx_data;
            w_nxt_last      = tx_last;
            w_nxt_need_byte = 1'b0;
            w_nxt_bit_idx   = IDX_W'(1);
            w_tx_bit        = tx_data[0];
            w_drive_bit     = 1'b1;
          end else begin
            w_nxt_underrun  = 1'b1;
            w_nxt_state     = EOP_SE0;
            w_nxt_need_byte = 1'b0;
            w_nxt_se0_cnt   = SE0_W'(1);
            w_nxt_dp        = 1'b0;
            w_nxt_dm        = 1'b0;
          end
        end else begin
          w_tx_bit    = r_shift[r_bit_idx];
          w_drive_bit = 1'b1;
          if (r_bit_idx == IDX_W'(7)) begin
            w_nxt_need_byte = 1'b1;
            w_nxt_bit_idx   = '0;
          end else begin
            w_nxt_bit_idx = r_bit_idx + IDX_W'(1);
          end
        end
      end

      EOP_SE0: begin
        if (r_se0_cnt >= SE0_W'(EOP_SE0_BITS)) begin
          w_nxt_state = EOP_J;
          w_nxt_dp    = 1'b1;
          w_nxt_dm    = 1'b0;
        end else begin
          w_nxt_se0_cnt = r_se0_cnt + SE0_W'(1);
          w_nxt_dp      = 1'b0;
          w_nxt_dm      = 1'b0;
        end
      end

      EOP_J: begin
        w_nxt_state    = IDLE;
        w_nxt_busy     = 1'b0;
        w_nxt_done     = 1'b1;
        w_nxt_dp       = 1'b1;
        w_nxt_dm       = 1'b0;
        w_nxt_se0_cnt  = '0;
        w_nxt_bit_idx  = '0;
        w_nxt_ones_cnt = '0;
        w_nxt_last     = 1'b0;
      end

      default: begin
        w_nxt_state = IDLE;
        w_nxt_dp    = 1'b1;
        w_nxt_dm    = 1'b0;
      end
    endcase

    // NRZI: a 1 holds the line and counts toward stuffing, a 0 toggles and clears the run.
    if (w_drive_bit) begin
      if (w_tx_bit) begin
        w_nxt_ones_cnt = r_ones_cnt + CNT_W'(1);
      end else begin
        w_nxt_dp       = ~r_dp;
        w_nxt_dm       = ~r_dm;
        w_nxt_ones_cnt = '0;
      end
    end
  end

  assign tx_ready    = w_tx_ready;
  assign tx_busy     = r_busy;
  assign tx_done     = r_done;
  assign tx_underrun = r_underrun;
  assign d_plus_out  = r_dp;
  assign d_minus_out = r_dm;

`ifdef USB_TX_OE_EN
  // Pad enable spans SYNC bit0 through the EOP J bit time, exactly the busy window.
  assign d_oe = r_busy;
`endif

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: directed, table-driven bench for usb_tx_encoder.
// Line encoding in expectation strings: J=(1,0), K=(0,1), '0'=SE0.
module tb_usb_tx_encoder;

  logic       clk;
  logic       n_rst;
  logic       bit_strobe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;
  logic       d_plus_out;
  logic       d_minus_out;
`ifdef USB_TX_OE_EN
  logic       d_oe;
`endif

  int n_vec;
  int n_err;

  usb_tx_encoder dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .bit_strobe  (bit_strobe),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun),
    .d_plus_out  (d_plus_out),
    .d_minus_out (d_minus_out)
`ifdef USB_TX_OE_EN
    ,
    .d_oe        (d_oe)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         nbytes;
    logic       lfin;
    string      line;
    int         rdy_a;
    int         rdy_b;
    logic       und;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input byte c);
    case (c)
      "J":     return 2'b10;
      "K":     return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // One bit time: raise bit_strobe for one clk, sample tx_ready before the edge.
  task automatic strobe(output logic rdy);
    @(negedge clk);
    bit_strobe = 1'b1;
    #1 rdy = tx_ready;
    @(posedge clk);
    #1 bit_strobe = 1'b0;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   idx;
    logic rdy;
    logic exp_rdy;
    v   = vecs[vi];
    idx = 0;
    for (int s = 1; s <= v.line.len(); s++) begin
      tx_valid = (idx < v.nbytes);
      tx_data  = (idx == 0) ? v.b0 : v.b1;
      tx_last  = (idx == v.nbytes - 1) ? v.lfin : 1'b0;
      strobe(rdy);
      exp_rdy = (s == v.rdy_a) || (s == v.rdy_b);
      check($sformatf("v%0d s%0d ready", vi, s), {7'd0, rdy}, {7'd0, exp_rdy});
      check($sformatf("v%0d s%0d line", vi, s), {6'd0, d_plus_out, d_minus_out},
            {6'd0, enc(v.line[s-1])});
      check($sformatf("v%0d s%0d busy", vi, s), {7'd0, tx_busy}, 8'd1);
`ifdef USB_TX_OE_EN
      check($sformatf("v%0d s%0d oe", vi, s), {7'd0, d_oe}, 8'd1);
`endif
      if (rdy && tx_valid) idx++;
    end
    tx_valid = 1'b0;
    strobe(rdy);
    check($sformatf("v%0d done", vi), {7'd0, tx_done}, 8'd1);
    check($sformatf("v%0d idle busy", vi), {7'd0, tx_busy}, 8'd0);
    check($sformatf("v%0d idle line", vi), {6'd0, d_plus_out, d_minus_out}, 8'd2);
    check($sformatf("v%0d underrun", vi), {7'd0, tx_underrun}, {7'd0, v.und});
    @(posedge clk);
    #1 check($sformatf("v%0d done clear", vi), {7'd0, tx_done}, 8'd0);
  endtask

  initial begin
    logic rdy;
    n_vec      = 0;
    n_err      = 0;
    n_rst      = 1'b0;
    bit_strobe = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;

    vecs[0] = '{8'h00, 8'h00, 1, 1'b1, "KJKJKJKKJKJKJKJK00J",      9,  0, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1, 1'b1, "KJKJKJKKKKKKKJJJJ00J",     9,  0, 1'b0};
    vecs[2] = '{8'h3F, 8'h00, 1, 1'b1, "KJKJKJKKKKKKKJJKJ00J",     9,  0, 1'b0};
    vecs[3] = '{8'hFC, 8'h00, 1, 1'b1, "KJKJKJKKJKKKKKKKJ00J",     9,  0, 1'b0};
    vecs[4] = '{8'hA5, 8'h5A, 2, 1'b1, "KJKJKJKKKJJKJJKKJJKKKJJK00J", 9, 17, 1'b0};
    vecs[5] = '{8'h12, 8'h00, 1, 1'b0, "KJKJKJKKJJKJJKJK00J",      9, 17, 1'b1};

    // Reset state
    #12;
    check("rst line", {6'd0, d_plus_out, d_minus_out}, 8'd2);
    check("rst busy", {7'd0, tx_busy}, 8'd0);
    check("rst done", {7'd0, tx_done}, 8'd0);
    check("rst underrun", {7'd0, tx_underrun}, 8'd0);
    check("rst ready", {7'd0, tx_ready}, 8'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Idle strobe without tx_valid stays J
    strobe(rdy);
    check("idle line", {6'd0, d_plus_out, d_minus_out}, 8'd2);
    check("idle busy", {7'd0, tx_busy}, 8'd0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // New packet clears sticky underrun left by the last vector; then reset mid-byte
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tx_last  = 1'b1;
    strobe(rdy);
    check("restart underrun", {7'd0, tx_underrun}, 8'd0);
    check("restart line", {6'd0, d_plus_out, d_minus_out}, 8'd1);
    for (int s = 2; s <= 12; s++) strobe(rdy);
    check("midbyte busy", {7'd0, tx_busy}, 8'd1);
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check("async rst line", {6'd0, d_plus_out, d_minus_out}, 8'd2);
    check("async rst busy", {7'd0, tx_busy}, 8'd0);
    check("async rst done", {7'd0, tx_done}, 8'd0);
    tx_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    strobe(rdy);
    check("post rst done", {7'd0, tx_done}, 8'd0);
    check("post rst line", {6'd0, d_plus_out, d_minus_out}, 8'd2);

    // tx_valid held through the done strobe is not sampled there
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tx_last  = 1'b1;
    for (int s = 1; s <= 19; s++) strobe(rdy);
    check("b2b eopj line", {6'd0, d_plus_out, d_minus_out}, 8'd2);
    check("b2b eopj busy", {7'd0, tx_busy}, 8'd1);
    strobe(rdy);
    check("b2b done ready", {7'd0, rdy}, 8'd0);
    check("b2b done", {7'd0, tx_done}, 8'd1);
    check("b2b gap busy", {7'd0, tx_busy}, 8'd0);
    check("b2b gap line", {6'd0, d_plus_out, d_minus_out}, 8'd2);
    strobe(rdy);
    check("b2b sync busy", {7'd0, tx_busy}, 8'd1);
    check("b2b sync line", {6'd0, d_plus_out, d_minus_out}, 8'd1);
    tx_valid = 1'b0;
    n_rst    = 1'b0;
    #20;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
